// File: rtl/axi4_wr_arbiter_2to1.sv
// axi4_wr_arbiter_2to1: round-robin arbiter of two AXI4 write masters onto one slave write path
module axi4_wr_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [1:0]              S_AWVALID,
  output logic [1:0]              S_AWREADY,
  input  logic [2*ADDR_W-1:0]     S_AWADDR,
  input  logic [15:0]             S_AWLEN,
  input  logic [5:0]              S_AWSIZE,
  input  logic [3:0]              S_AWBURST,
  input  logic [2*ID_W-1:0]       S_AWID,
  input  logic [1:0]              S_WVALID,
  output logic [1:0]              S_WREADY,
  input  logic [2*DATA_W-1:0]     S_WDATA,
  input  logic [2*DATA_W/8-1:0]   S_WSTRB,
  input  logic [1:0]              S_WLAST,
  output logic [1:0]              S_BVALID,
  input  logic [1:0]              S_BREADY,
  output logic [3:0]              S_BRESP,
  output logic [2*ID_W-1:0]       S_BID,
  output logic                    M_AWVALID,
  output logic [ADDR_W-1:0]       M_AWADDR,
  output logic [7:0]              M_AWLEN,
  output logic [2:0]              M_AWSIZE,
  output logic [1:0]              M_AWBURST,
  output logic [ID_W-1:0]         M_AWID,
  input  logic                    M_AWREADY,
  output logic                    M_WVALID,
  output logic [DATA_W-1:0]       M_WDATA,
  output logic [DATA_W/8-1:0]     M_WSTRB,
  output logic                    M_WLAST,
  input  logic                    M_WREADY,
  input  logic                    M_BVALID,
  input  logic [1:0]              M_BRESP,
  input  logic [ID_W-1:0]         M_BID,
  output logic                    M_BREADY,
  output logic [1:0]              GRANT,
  output logic                    PROTO_ERR
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant_nxt;
  logic        g, pick, rr_ptr, rr_seen;
  logic        in_addr, in_data, in_resp;
  logic        aw_hs, w_hs, b_hs, beat_mism;
  logic [7:0]  awlen_q;
  logic [8:0]  beat_cnt;
  logic        mism_q;
  logic [1:0]  b_resp;

  assign g       = GRANT[1];
  assign in_addr = state == ADDR;
  assign in_data = state == DATA;
  assign in_resp = state == RESP;
  assign aw_hs   = in_addr && M_AWVALID && M_AWREADY;
  assign w_hs    = in_data && M_WVALID && M_WREADY;
  assign b_hs    = in_resp && M_BVALID && M_BREADY;

  // On contention favour the requester that was not served last; requester 0 until a burst completes
  assign pick = (&S_AWVALID) ? (rr_seen && !rr_ptr) : S_AWVALID[1];

  // A beat is wrong when WLAST disagrees with whether this beat closes the declared length
  assign beat_mism = M_WLAST != (beat_cnt == {1'b0, awlen_q});

  // A mismatched burst turns an OKAY response into SLVERR; other responses pass untouched
  assign b_resp = (mism_q && M_BRESP == 2'b00) ? 2'b10 : M_BRESP;

  // Next-state and grant selection for the single outstanding burst
  always_comb begin
    state_nxt = state;
    grant_nxt = GRANT;
    case (state)
      IDLE: if (|S_AWVALID) begin
        state_nxt = ADDR;
        grant_nxt = pick ? 2'b10 : 2'b01;
      end
      ADDR: if (aw_hs) state_nxt = DATA;
      DATA: if (w_hs && M_WLAST) state_nxt = RESP;
      RESP: if (b_hs) begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // State and owner registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      GRANT <= 2'b00;
    end else begin
      state <= state_nxt;
      GRANT <= grant_nxt;
    end
  end

  // Remember who was served last once a response has been returned
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr  <= 1'b0;
      rr_seen <= 1'b0;
    end else if (b_hs) begin
      rr_ptr  <= g;
      rr_seen <= 1'b1;
    end
  end

  // Per-burst length tracking and WLAST consistency flags
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awlen_q   <= 8'd0;
      beat_cnt  <= 9'd0;
      mism_q    <= 1'b0;
      PROTO_ERR <= 1'b0;
    end else begin
      if (aw_hs) begin
        awlen_q  <= M_AWLEN;
        beat_cnt <= 9'd0;
        mism_q   <= 1'b0;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (beat_mism) begin
          mism_q    <= 1'b1;
          PROTO_ERR <= 1'b1;
        end
      end
    end
  end

  assign M_AWVALID = in_addr && S_AWVALID[g];
  assign M_AWADDR  = in_addr ? S_AWADDR[g*ADDR_W +: ADDR_W] : '0;
  assign M_AWLEN   = in_addr ? S_AWLEN[g*8 +: 8] : '0;
  assign M_AWSIZE  = in_addr ? S_AWSIZE[g*3 +: 3] : '0;
  assign M_AWBURST = in_addr ? S_AWBURST[g*2 +: 2] : '0;
  assign M_AWID    = in_addr ? S_AWID[g*ID_W +: ID_W] : '0;
  assign S_AWREADY = {2{in_addr && M_AWREADY}} & GRANT;

  assign M_WVALID  = in_data && S_WVALID[g];
  assign M_WDATA   = in_data ? S_WDATA[g*DATA_W +: DATA_W] : '0;
  assign M_WSTRB   = in_data ? S_WSTRB[g*STRB_W +: STRB_W] : '0;
  assign M_WLAST   = in_data && S_WLAST[g];
  assign S_WREADY  = {2{in_data && M_WREADY}} & GRANT;

  assign M_BREADY  = in_resp && S_BREADY[g];
  assign S_BVALID  = {2{in_resp && M_BVALID}} & GRANT;
  assign S_BRESP   = in_resp ? (g ? {b_resp, 2'b00} : {2'b00, b_resp}) : '0;
  assign S_BID     = in_resp ? (g ? {M_BID, {ID_W{1'b0}}} : {{ID_W{1'b0}}, M_BID}) : '0;
endmodule

// File: tb/tb_axi4_wr_arbiter_2to1.sv
// tb_axi4_wr_arbiter_2to1: directed bench with a transaction-level model checked every cycle
module tb_axi4_wr_arbiter_2to1;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic [1:0]  S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_WLAST, S_BVALID, S_BREADY;
  logic [63:0] S_AWADDR, S_WDATA;
  logic [15:0] S_AWLEN;
  logic [5:0]  S_AWSIZE;
  logic [3:0]  S_AWBURST, S_BRESP;
  logic [7:0]  S_AWID, S_WSTRB, S_BID;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WLAST, M_WREADY, M_BVALID, M_BREADY, PROTO_ERR;
  logic [31:0] M_AWADDR, M_WDATA;
  logic [7:0]  M_AWLEN;
  logic [2:0]  M_AWSIZE;
  logic [1:0]  M_AWBURST, M_BRESP, GRANT;
  logic [3:0]  M_AWID, M_WSTRB, M_BID;

  axi4_wr_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
    .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST), .S_AWID(S_AWID),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP), .S_BID(S_BID),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWID(M_AWID), .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BRESP(M_BRESP), .M_BID(M_BID), .M_BREADY(M_BREADY),
    .GRANT(GRANT), .PROTO_ERR(PROTO_ERR)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  bit          j_on[2], j_aw[2];
  int          j_len[2], j_beats[2], j_sent[2], done_cnt[2];
  logic [31:0] j_addr[2];
  logic [3:0]  j_id[2], got_id[2];
  logic [1:0]  got_resp[2];
  int          aw_stall;
  bit          w_toggle;
  logic [1:0]  sl_resp;
  logic [3:0]  sl_bid;
  logic [31:0] slv_q[$];
  int          grant_log[$];
  logic [1:0]  prev_grant;
  bit          awv_seen;
  bit          aw_h[2], w_h[2], b_h[2];
  bit          mw, mwl, mb, mawv;

  int owner, last_g, m_len, m_cnt;
  bit aw_done, w_done, m_flag, m_perr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic post(input int i, input int len, input int beats, input logic [31:0] addr, input logic [3:0] id);
    j_on[i] = 1'b1;
    j_aw[i] = 1'b0;
    j_len[i] = len;
    j_beats[i] = beats;
    j_sent[i] = 0;
    j_addr[i] = addr;
    j_id[i] = id;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      S_AWVALID[i] = j_on[i] && !j_aw[i];
      S_AWADDR[i*32 +: 32] = j_addr[i];
      S_AWLEN[i*8 +: 8] = 8'(j_len[i]);
      S_AWSIZE[i*3 +: 3] = (i == 1) ? 3'd1 : 3'd2;
      S_AWBURST[i*2 +: 2] = (i == 1) ? 2'b00 : 2'b01;
      S_AWID[i*4 +: 4] = j_id[i];
      S_WVALID[i] = j_on[i] && j_aw[i] && (j_sent[i] < j_beats[i]);
      S_WDATA[i*32 +: 32] = j_addr[i] + 32'(j_sent[i]);
      S_WSTRB[i*4 +: 4] = 4'(j_sent[i]) | 4'h1;
      S_WLAST[i] = j_sent[i] == j_beats[i] - 1;
    end
    S_BREADY = 2'b11;
  endtask

  task automatic sample();
    int o;
    bit adr, dat, rsp;
    logic [1:0] br;
    @(negedge ACLK);
    if (!ARESETn) begin
      owner = -1; last_g = -1; m_len = 0; m_cnt = 0;
      aw_done = 0; w_done = 0; m_flag = 0; m_perr = 0;
      prev_grant = 2'b00;
      chk("reset_outputs", {GRANT, PROTO_ERR, M_AWVALID, M_WVALID, M_BREADY, S_AWREADY, S_WREADY,
                            S_BVALID, S_BRESP, S_BID, M_AWADDR, M_WDATA}, 64'd0);
    end else begin
      o = (owner < 0) ? 0 : owner;
      adr = owner >= 0 && !aw_done;
      dat = owner >= 0 && aw_done && !w_done;
      rsp = owner >= 0 && w_done;
      br = (m_flag && M_BRESP == 2'b00) ? 2'b10 : M_BRESP;
      chk("grant", GRANT, (owner < 0) ? 64'd0 : 64'd1 << o);
      chk("m_awvalid", M_AWVALID, adr && S_AWVALID[o]);
      chk("m_aw_fields", {M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID},
          adr ? {S_AWADDR[o*32 +: 32], S_AWLEN[o*8 +: 8], S_AWSIZE[o*3 +: 3], S_AWBURST[o*2 +: 2], S_AWID[o*4 +: 4]} : 49'd0);
      chk("s_awready", S_AWREADY, (adr && M_AWREADY) ? 64'd1 << o : 64'd0);
      chk("m_wvalid", M_WVALID, dat && S_WVALID[o]);
      chk("m_w_fields", {M_WDATA, M_WSTRB, M_WLAST},
          dat ? {S_WDATA[o*32 +: 32], S_WSTRB[o*4 +: 4], S_WLAST[o]} : 37'd0);
      chk("s_wready", S_WREADY, (dat && M_WREADY) ? 64'd1 << o : 64'd0);
      chk("s_bvalid", S_BVALID, (rsp && M_BVALID) ? 64'd1 << o : 64'd0);
      chk("m_bready", M_BREADY, rsp && S_BREADY[o]);
      chk("s_bresp", S_BRESP, rsp ? 64'(br) << (2*o) : 64'd0);
      chk("s_bid", S_BID, rsp ? 64'(M_BID) << (4*o) : 64'd0);
      chk("proto_err", PROTO_ERR, m_perr);
      if (GRANT != prev_grant && GRANT != 2'b00) grant_log.push_back(int'(GRANT[1]));
      prev_grant = GRANT;
      if (owner < 0) begin
        if (|S_AWVALID) begin
          owner = (S_AWVALID == 2'b11) ? ((last_g < 0) ? 0 : 1 - last_g) : (S_AWVALID[1] ? 1 : 0);
          aw_done = 0;
          w_done = 0;
        end
      end else if (adr) begin
        if (S_AWVALID[o] && M_AWREADY) begin
          aw_done = 1; m_len = int'(S_AWLEN[o*8 +: 8]); m_cnt = 0; m_flag = 0;
        end
      end else if (dat) begin
        if (S_WVALID[o] && M_WREADY) begin
          m_cnt++;
          if (S_WLAST[o] != (m_cnt == m_len + 1)) begin
            m_flag = 1;
            m_perr = 1;
          end
          if (S_WLAST[o]) w_done = 1;
        end
      end else if (M_BVALID && S_BREADY[o]) begin
        last_g = o;
        owner = -1;
      end
    end
    awv_seen = M_AWVALID;
    for (int i = 0; i < 2; i++) begin
      aw_h[i] = S_AWVALID[i] && S_AWREADY[i];
      w_h[i] = S_WVALID[i] && S_WREADY[i];
      b_h[i] = S_BVALID[i] && S_BREADY[i];
      if (b_h[i]) begin
        got_resp[i] = S_BRESP[i*2 +: 2];
        got_id[i] = S_BID[i*4 +: 4];
      end
    end
    mw = M_WVALID && M_WREADY;
    mwl = M_WLAST;
    mb = M_BVALID && M_BREADY;
    mawv = M_AWVALID;
    if (mw) slv_q.push_back(M_WDATA);
  endtask

  task automatic settle();
    @(posedge ACLK);
    #1;
    if (!ARESETn) begin
      for (int i = 0; i < 2; i++) begin
        j_on[i] = 0;
        j_aw[i] = 0;
        j_sent[i] = 0;
      end
      aw_stall = 0;
      M_AWREADY = 1'b1;
      M_WREADY = 1'b1;
      M_BVALID = 1'b0;
      M_BRESP = 2'b00;
      M_BID = 4'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (aw_h[i]) j_aw[i] = 1;
        if (w_h[i]) j_sent[i]++;
        if (b_h[i]) begin
          j_on[i] = 0;
          done_cnt[i]++;
        end
      end
      if (mawv && !M_AWREADY && aw_stall > 0) aw_stall--;
      M_AWREADY = aw_stall == 0;
      M_WREADY = w_toggle ? !M_WREADY : 1'b1;
      if (mb) M_BVALID = 1'b0;
      if (mw && mwl) begin
        M_BVALID = 1'b1;
        M_BRESP = sl_resp;
        M_BID = sl_bid;
      end
    end
  endtask

  task automatic step();
    drive();
    sample();
    settle();
  endtask

  task automatic wait_done(input int i, input int target, input string name);
    int n = 0;
    while (done_cnt[i] < target && n < 200) begin
      step();
      n++;
    end
    chk(name, done_cnt[i] >= target, 1);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    repeat (2) step();
    ARESETn = 1'b1;
    grant_log.delete();
    slv_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, d1;
    S_AWVALID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWID = '0;
    S_WVALID = '0; S_WDATA = '0; S_WSTRB = '0; S_WLAST = '0; S_BREADY = '0;
    M_AWREADY = 1'b1; M_WREADY = 1'b1; M_BVALID = 1'b0; M_BRESP = 2'b00; M_BID = 4'h0;
    aw_stall = 0; w_toggle = 0; sl_resp = 2'b00; sl_bid = 4'h0;
    for (int i = 0; i < 2; i++) begin
      j_on[i] = 0; j_aw[i] = 0; j_len[i] = 0; j_beats[i] = 0; j_sent[i] = 0;
      j_addr[i] = '0; j_id[i] = '0; done_cnt[i] = 0; got_resp[i] = 2'b00; got_id[i] = 4'h0;
    end
    #2 ARESETn = 1'b0;
    #1;
    chk("rst_grant", GRANT, 2'b00);
    chk("rst_proto_err", PROTO_ERR, 1'b0);
    chk("rst_m_valids", {M_AWVALID, M_WVALID, M_BREADY}, 3'b000);
    do_reset();

    // single requester, 4-beat burst
    sl_resp = 2'b00; sl_bid = 4'h5;
    post(0, 3, 4, 32'h1000, 4'h5);
    n = 0;
    step();
    while (!awv_seen && n < 10) begin
      n++;
      step();
    end
    chk("t1_aw_latency", n, 1);
    chk("t1_grant", GRANT, 2'b01);
    wait_done(0, 1, "t1_done");
    chk("t1_beats", slv_q.size(), 4);
    chk("t1_first_beat", slv_q[0], 32'h1000);
    chk("t1_last_beat", slv_q[3], 32'h1003);
    chk("t1_bresp", got_resp[0], 2'b00);
    chk("t1_grant_idle", GRANT, 2'b00);

    // round-robin alternation from reset
    do_reset();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    post(0, 0, 1, 32'h2000, 4'h1);
    post(1, 0, 1, 32'h2100, 4'h2);
    wait_done(0, d0 + 1, "t2_r1_s0");
    wait_done(1, d1 + 1, "t2_r1_s1");
    post(0, 0, 1, 32'h2000, 4'h1);
    post(1, 0, 1, 32'h2100, 4'h2);
    wait_done(0, d0 + 2, "t2_r2_s0");
    wait_done(1, d1 + 2, "t2_r2_s1");
    chk("t2_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_order%0d", k), grant_log[k], k % 2);

    // AW stall and toggling WREADY with the other requester waiting
    slv_q.delete();
    aw_stall = 3; w_toggle = 1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    post(0, 3, 4, 32'h3000, 4'h3);
    post(1, 0, 1, 32'h3100, 4'h4);
    wait_done(0, d0 + 1, "t3_s0");
    wait_done(1, d1 + 1, "t3_s1");
    w_toggle = 0;
    chk("t3_beats", slv_q.size(), 5);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_beat%0d", k), slv_q[k], 32'h3000 + 32'(k));
    chk("t3_s1_beat", slv_q[4], 32'h3100);
    chk("t3_stall_used", aw_stall, 0);

    // early WLAST, sticky error, missing WLAST, non-OKAY passthrough
    sl_resp = 2'b00;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    post(0, 1, 1, 32'h4000, 4'h6);
    wait_done(0, d0 + 1, "t4_short_done");
    chk("t4_proto_err", PROTO_ERR, 1'b1);
    chk("t4_short_bresp", got_resp[0], 2'b10);
    post(0, 1, 2, 32'h4010, 4'h6);
    wait_done(0, d0 + 2, "t4_good_done");
    chk("t4_good_bresp", got_resp[0], 2'b00);
    chk("t4_proto_sticky", PROTO_ERR, 1'b1);
    post(1, 0, 2, 32'h4100, 4'h7);
    wait_done(1, d1 + 1, "t4_long_done");
    chk("t4_long_bresp", got_resp[1], 2'b10);
    sl_resp = 2'b01;
    post(1, 0, 2, 32'h4200, 4'h7);
    wait_done(1, d1 + 2, "t4_exokay_done");
    chk("t4_exokay_kept", got_resp[1], 2'b01);

    // DECERR and BID passthrough on requester 1
    sl_resp = 2'b11; sl_bid = 4'h9;
    d1 = done_cnt[1];
    post(1, 2, 3, 32'h5000, 4'h7);
    wait_done(1, d1 + 1, "t5_done");
    chk("t5_bresp", got_resp[1], 2'b11);
    chk("t5_bid", got_id[1], 4'h9);

    // asynchronous reset while beat 2 of 4 is presented
    sl_resp = 2'b00; sl_bid = 4'h2;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    post(0, 3, 4, 32'h6000, 4'h1);
    n = 0;
    while (j_sent[0] < 1 && n < 50) begin
      step();
      n++;
    end
    chk("t6_reach_beat2", j_sent[0] >= 1, 1);
    drive();
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_async_zero", {GRANT, M_WVALID, M_AWVALID, S_WREADY, S_AWREADY, M_BREADY, PROTO_ERR, M_WDATA}, 64'd0);
    sample();
    settle();
    step();
    ARESETn = 1'b1;
    grant_log.delete();
    post(1, 0, 1, 32'h6100, 4'h2);
    wait_done(1, d1 + 1, "t6_s1_done");
    chk("t6_grant_log", {32'(grant_log.size()), 32'(grant_log[0])}, {32'd1, 32'd1});
    chk("t6_bresp", got_resp[1], 2'b00);
    chk("t6_no_abandoned_b", done_cnt[0], d0);
    chk("t6_proto_clear", PROTO_ERR, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_wr_arbiter_2to1.md
Name: axi4_wr_arbiter_2to1

Overview:
Arbitrates two AXI4 write requesters onto one shared AXI4 slave write path (AW, W, B channels).
- Only one burst is in flight at a time.
- Round-robin fairness between the two requesters.
- The W stream is locked to the granted requester until WLAST.
- The B response is routed back to the granted requester; a beat-count mismatch turns OKAY into SLVERR.

It sits between the master-side bus ports and the slave interface that the protocol checkers monitor.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (STRB width = DATA_W/8)
ID_W, 4, transaction ID width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
S_AWVALID  in  2  per-requester AW valid (bit i = requester i)
S_AWREADY  out  2  per-requester AW ready
S_AWADDR  in  2*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
S_AWLEN  in  2*8  burst length-1
S_AWSIZE  in  2*3  beat size
S_AWBURST  in  2*2  burst type
S_AWID  in  2*ID_W  write ID
S_WVALID  in  2  W valid
S_WREADY  out  2  W ready
S_WDATA  in  2*DATA_W  W data
S_WSTRB  in  2*DATA_W/8  W strobes
S_WLAST  in  2  W last
S_BVALID  out  2  B valid
S_BREADY  in  2  B ready
S_BRESP  out  2*2  B response
S_BID  out  2*ID_W  B ID
M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID  out  1/ADDR_W/8/3/2/ID_W  shared AW
M_AWREADY  in  1  slave AW ready
M_WVALID, M_WDATA, M_WSTRB, M_WLAST  out  1/DATA_W/DATA_W/8/1  shared W
M_WREADY  in  1  slave W ready
M_BVALID, M_BRESP, M_BID  in  1/2/ID_W  slave B
M_BREADY  out  1  B ready to slave
GRANT  out  2  one-hot current owner, 0 when idle
PROTO_ERR  out  1  sticky: WLAST/beat-count mismatch seen

Behaviour:
Reset (ARESETn low, asynchronous):
- state IDLE, GRANT=0, rr pointer=0 (requester 0 favoured first), beat counter=0, PROTO_ERR=0, captured mismatch flag=0.
- All outputs are 0.
- Reset mid-burst abandons the transaction; no B is delivered.

State IDLE:
- If any S_AWVALID is high, select owner:
  - Only one valid → that requester.
  - Both valid → the requester not equal to rr pointer's last-granted index (requester 0 after reset).
- Register GRANT and go to ADDR. Grant decision takes one cycle: M_AWVALID rises no earlier than the cycle after S_AWVALID.

State ADDR:
- M_AW* = granted requester's AW fields; M_AWVALID = S_AWVALID[g]; S_AWREADY[g] = M_AWREADY.
- Non-granted S_AWREADY = 0.
- On handshake: latch AWLEN, clear beat counter, clear mismatch flag, go to DATA.

State DATA:
- M_W* = granted requester's W fields; S_WREADY[g] = M_WREADY; other S_WREADY = 0.
- On each W handshake, increment the 9-bit beat counter.
- Mismatch is flagged when:
  - WLAST is asserted on a beat where count+1 != AWLEN+1, or
  - count+1 == AWLEN+1 without WLAST.
- On the mismatch beat, set the mismatch flag and PROTO_ERR.
- On handshake with WLAST high, go to RESP. A missing WLAST is not terminated early: keep forwarding until WLAST.

State RESP:
- S_BVALID[g] = M_BVALID; M_BREADY = S_BREADY[g]; S_BID[g] = M_BID.
- S_BRESP[g] = 2'b10 if the mismatch flag is set and M_BRESP == 2'b00; otherwise M_BRESP.
- On B handshake: rr pointer = g, GRANT = 0, go to IDLE.
- A new grant is decided in the following cycle, so there is a minimum one idle cycle between bursts.

Channel isolation: the non-granted requester sees all READY/BVALID low and is held off until IDLE.

Simultaneous events:
- An AWVALID arriving in any non-IDLE state waits.
- Slave B arriving in the same cycle as the WLAST handshake is accepted in RESP (the slave holds it).

PROTO_ERR is cleared only by reset.

Test Plan:
1. Single requester: S0 AWLEN=3, 4 beats with WLAST on beat 4, slave BRESP=00 → GRANT=01, M_AWVALID one cycle after S_AWVALID, 4 beats forwarded, S_BRESP[0]=00, GRANT→00.
2. Both requesters assert AWVALID in the same cycle after reset → S0 served first, then S1; if both request again, S0 is served next (alternation 0,1,0,1 over 4 bursts).
3. Backpressure: M_AWREADY low 3 cycles, M_WREADY toggling every cycle → no beat lost or duplicated, W order preserved, S1 remains stalled with S_AWREADY[1]=0.
4. S0 AWLEN=1 but WLAST on beat 1 → PROTO_ERR=1, slave BRESP=00 delivered as S_BRESP[0]=10, PROTO_ERR stays 1 across later good bursts.
5. Slave BRESP=11 (DECERR) on S1 burst → S_BRESP[1]=11 passed unchanged; S_BID[1]=M_BID.
6. ARESETn pulled low mid DATA (beat 2 of 4) → all outputs 0 immediately; after release, a new S1 request is granted cleanly with rr pointer=0.
